// File: rtl/gpio_bus_sequencer.sv
// Host GPIO command word sequencer: forwards one command at a time onto a
// four-block request/acknowledge bus and reports completion in a status word.
module gpio_bus_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] gpio1_i,
    output logic [31:0] gpio2_o,
    output logic [3:0]  req_o,
    input  logic [3:0]  ack_i,
    output logic        we_o,
    output logic [11:0] addr_o,
    output logic [15:0] wdata_o,
    input  logic [15:0] rdata0_i,
    input  logic [15:0] rdata1_i,
    input  logic [15:0] rdata2_i,
    input  logic [15:0] rdata3_i
);

    localparam logic [15:0] LP_TMO = TIMEOUT_CYCLES[15:0];

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cmd_q;
    logic        r_tog;
    logic [1:0]  r_blk;
    logic        r_we;
    logic [11:0] r_addr;
    logic [15:0] r_wdata;
    logic [3:0]  r_req;
    logic [15:0] r_cnt;
    logic        r_done_tog;
    logic        r_err;
    logic [1:0]  r_last_blk;
    logic [15:0] r_rdata;

    logic        w_start;
    logic        w_finish;
    logic        w_ack;
    logic        w_tmo;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_rsel;
    logic        w_busy;

    assign w_ack     = ack_i[r_blk];
    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_tmo     = (w_cnt_nxt == LP_TMO);
    assign w_busy    = (r_state == REQ);

    always_comb begin
        w_rsel = rdata0_i;
        unique case (r_blk)
            2'd0: w_rsel = rdata0_i;
            2'd1: w_rsel = rdata1_i;
            2'd2: w_rsel = rdata2_i;
            2'd3: w_rsel = rdata3_i;
            default: w_rsel = rdata0_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_cmd_q[31] != r_done_tog) begin
                    w_next  = REQ;
                    w_start = 1'b1;
                end
            end
            REQ: begin
                if (w_ack || w_tmo) begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Status fields change only when a transaction finishes; ack beats timeout.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cmd_q    <= '0;
            r_tog      <= 1'b0;
            r_blk      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_req      <= '0;
            r_cnt      <= '0;
            r_done_tog <= 1'b0;
            r_err      <= 1'b0;
            r_last_blk <= '0;
            r_rdata    <= '0;
        end else begin
            r_cmd_q <= gpio1_i;
            if (w_start) begin
                r_tog   <= r_cmd_q[31];
                r_blk   <= r_cmd_q[30:29];
                r_we    <= r_cmd_q[28];
                r_addr  <= r_cmd_q[27:16];
                r_wdata <= r_cmd_q[15:0];
                r_cnt   <= '0;
                r_req   <= 4'b0001 << r_cmd_q[30:29];
            end else if (r_state == REQ) begin
                r_cnt <= w_cnt_nxt;
                if (w_finish) begin
                    r_req      <= '0;
                    r_done_tog <= r_tog;
                    r_last_blk <= r_blk;
                    r_err      <= ~w_ack;
                    r_rdata    <= (w_ack && !r_we) ? w_rsel : 16'd0;
                end
            end
        end
    end

    assign req_o   = r_req;
    assign we_o    = r_we;
    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign gpio2_o = {r_done_tog, r_err, w_busy, 11'd0, r_last_blk, r_rdata};

endmodule

// File: tb/tb_gpio_bus_sequencer.sv
// Randomized self-checking bench for gpio_bus_sequencer against a
// transaction-level expectation model.
module tb_gpio_bus_sequencer;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] gpio1_i = '0;
    logic [31:0] gpio2_o;
    logic [3:0]  req_o;
    logic [3:0]  ack_i = '0;
    logic        we_o;
    logic [11:0] addr_o;
    logic [15:0] wdata_o;
    logic [15:0] rd[4] = '{16'd0, 16'd0, 16'd0, 16'd0};

    gpio_bus_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk), .rst_i(rst_i), .gpio1_i(gpio1_i), .gpio2_o(gpio2_o),
        .req_o(req_o), .ack_i(ack_i), .we_o(we_o), .addr_o(addr_o),
        .wdata_o(wdata_o), .rdata0_i(rd[0]), .rdata1_i(rd[1]),
        .rdata2_i(rd[2]), .rdata3_i(rd[3])
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    bit          m_tog = 0, m_err = 0, m_busy = 0;
    logic [1:0]  m_blk = '0;
    logic [15:0] m_rd = '0;
    logic [3:0]  e_req = '0;
    logic        e_we = 0;
    logic [11:0] e_addr = '0;
    logic [15:0] e_wd = '0;

    int          hi_cnt = 0;
    int          low_run = 0;
    int          min_gap = 1000;
    bit          seen_hi = 0;
    logic [3:0]  prev_req = '0;
    logic [3:0]  seen_req = '0;

    function automatic logic [31:0] e_g2();
        return {m_tog, m_err, m_busy, 11'd0, m_blk, m_rd};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req_o", {28'd0, req_o}, {28'd0, e_req});
        chk("we_o", {31'd0, we_o}, {31'd0, e_we});
        chk("addr_o", {20'd0, addr_o}, {20'd0, e_addr});
        chk("wdata_o", {16'd0, wdata_o}, {16'd0, e_wd});
        chk("gpio2_o", gpio2_o, e_g2());
        if (req_o != 0) begin
            hi_cnt++;
            if (prev_req == 0 && seen_hi && low_run < min_gap) min_gap = low_run;
            if (prev_req != 0 && prev_req != req_o) min_gap = 0;
            seen_hi = 1;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_req = req_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_model();
        m_tog = 0; m_err = 0; m_busy = 0; m_blk = '0; m_rd = '0;
        e_req = '0; e_we = 0; e_addr = '0; e_wd = '0;
    endtask

    task automatic gaps(input int g);
        for (int i = 0; i < g; i++) begin
            gpio1_i = {m_tog, 31'($urandom)};
            ack_i = 4'($urandom);
            tick();
        end
    endtask

    // d = REQ cycles before ack (0 = ack in first REQ cycle); d+1 > T means timeout
    task automatic txn(input bit tog, input logic [1:0] blk, input bit we,
                       input logic [11:0] a, input logic [15:0] wd,
                       input int d, input logic [15:0] rdv,
                       input logic [3:0] nfix, input bit rnd,
                       input bit pre, input bit chg, input logic [31:0] nxt);
        int n;
        bit hit;
        if (!pre) gpio1_i = {tog, blk, we, a, wd};
        ack_i = rnd ? 4'($urandom) : nfix;
        tick();
        tick();
        hit = (d + 1 <= T);
        n = hit ? d + 1 : T;
        e_req = 4'b0001 << blk;
        e_we = we; e_addr = a; e_wd = wd; m_busy = 1;
        seen_req = req_o;
        for (int k = 1; k <= n; k++) begin
            ack_i = (rnd ? 4'($urandom) : nfix) & ~(4'b0001 << blk);
            if (hit && k == n) ack_i[blk] = 1'b1;
            for (int b = 0; b < 4; b++) rd[b] = 16'($urandom);
            if (k == n) rd[blk] = rdv;
            if (chg && k == 1) gpio1_i = nxt;
            tick();
        end
        e_req = '0; m_busy = 0;
        m_tog = tog; m_err = !hit; m_blk = blk;
        m_rd = (hit && !we) ? rdv : 16'd0;
    endtask

    initial begin
        bit          pend;
        bit          chg;
        logic [31:0] pc;
        logic [31:0] c;
        tick();
        tick();
        chk("reset_gpio2", gpio2_o, 32'h0);
        chk("reset_req", {28'd0, req_o}, 32'h0);
        rst_i = 0;
        tick();

        txn(1'b1, 2'd1, 1'b0, 12'h012, 16'h0, 1, 16'hBEEF, 4'h0, 0, 0, 0, '0);
        chk("read_req", {28'd0, seen_req}, 32'h2);
        chk("read_gpio2", gpio2_o, 32'h8001_BEEF);
        chk("read_model", e_g2(), 32'h8001_BEEF);

        txn(1'b0, 2'd3, 1'b1, 12'h345, 16'h1234, 2, 16'hFFFF, 4'h0, 0, 0, 0, '0);
        chk("wr_req", {28'd0, seen_req}, 32'h8);
        chk("wr_we", {31'd0, we_o}, 32'h1);
        chk("wr_addr", {20'd0, addr_o}, 32'h345);
        chk("wr_wdata", {16'd0, wdata_o}, 32'h1234);
        chk("wr_gpio2", gpio2_o, 32'h0003_0000);

        hi_cnt = 0;
        txn(1'b1, 2'd2, 1'b0, 12'h0AA, 16'h0, 100, 16'h7777, 4'h0, 0, 0, 0, '0);
        chk("tmo_len", hi_cnt, 8);
        chk("tmo_err", {31'd0, gpio2_o[30]}, 32'h1);
        chk("tmo_rd", {16'd0, gpio2_o[15:0]}, 32'h0);
        chk("tmo_gpio2", gpio2_o, 32'hC002_0000);

        txn(1'b0, 2'd0, 1'b0, 12'h001, 16'h0, T - 1, 16'h5A5A, 4'b0100, 0, 0, 0, '0);
        chk("simul_err", {31'd0, gpio2_o[30]}, 32'h0);
        chk("simul_gpio2", gpio2_o, 32'h0000_5A5A);

        min_gap = 1000;
        c = {1'b0, 2'd2, 1'b0, 12'h200, 16'h0};
        txn(1'b1, 2'd1, 1'b0, 12'h100, 16'h0, 3, 16'h1111, 4'h0, 0, 0, 1, c);
        chk("mid_first", gpio2_o, 32'h8001_1111);
        txn(1'b0, 2'd2, 1'b0, 12'h200, 16'h0, 0, 16'h2222, 4'h0, 0, 1, 0, '0);
        chk("mid_second", gpio2_o, 32'h0002_2222);
        chk("mid_gap", min_gap, 2);

        gpio1_i = {~m_tog, 2'd2, 1'b0, 12'h0AB, 16'h0};
        tick();
        tick();
        e_req = 4'b0100; e_we = 0; e_addr = 12'h0AB; e_wd = '0; m_busy = 1;
        tick();
        zero_model();
        #1 rst_i = 1;
        #1;
        chk("rst_req_async", {28'd0, req_o}, 32'h0);
        chk("rst_gpio2", gpio2_o, 32'h0);
        ack_i = 4'hF;
        gpio1_i = '0;
        tick();
        tick();
        rst_i = 0;
        tick();
        tick();
        tick();
        chk("rst_late_ack", {28'd0, req_o}, 32'h0);
        txn(1'b1, 2'd3, 1'b0, 12'h7FF, 16'h0, 0, 16'hC0DE, 4'h0, 0, 0, 0, '0);
        chk("post_rst", gpio2_o, 32'h8003_C0DE);

        pend = 0;
        pc = '0;
        for (int i = 0; i < 40; i++) begin
            chg = (($urandom % 4) == 0) && (i != 39);
            if (!pend) begin
                gaps(int'($urandom % 4));
                pc = {~m_tog, 31'($urandom)};
            end
            c = {~pc[31], 31'($urandom)};
            txn(pc[31], pc[30:29], pc[28], pc[27:16], pc[15:0],
                int'($urandom_range(0, 10)), 16'($urandom), 4'h0, 1,
                pend, chg, c);
            pend = chg;
            pc = c;
        end
        ack_i = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
